// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared arithmetic types, width default and sign helpers
package seq_divider_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // Two's-complement negate when neg is set; callers truncate to their own width (<= 64).
    function automatic logic [63:0] cond_negate(input logic [63:0] x, input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

    function automatic logic [63:0] abs_val(input logic [63:0] x, input logic sign);
        return cond_negate(x, sign);
    endfunction

endpackage

// File: rtl/div_datapath.sv
// rtl/div_datapath.sv - restoring divider datapath: R/Q/D, subtractor, counter, sign fix
module div_datapath
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         fix,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         cnt_one,
    output logic         d_zero,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  q_reg, d_reg, r_reg;
    logic [CW-1:0] cnt;
    logic          sq, sd;
    logic [W:0]    r_sh, t;

    // R < D always holds between steps, so W bits suffice for the stored remainder.
    always_comb begin
        r_sh = {r_reg, q_reg[W-1]};
        t    = r_sh - {1'b0, d_reg};
    end

    assign cnt_one = (cnt == CW'(1));
    assign d_zero  = (d_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            sq          <= 1'b0;
            sd          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            sq    <= dividend[W-1];
            sd    <= dividend[W-1] ^ divisor[W-1];
            q_reg <= W'(abs_val(64'(dividend), dividend[W-1]));
            d_reg <= W'(abs_val(64'(divisor), divisor[W-1]));
            r_reg <= '0;
            cnt   <= CW'(W);
        end else if (step) begin
            if (!t[W]) begin
                r_reg <= t[W-1:0];
                q_reg <= {q_reg[W-2:0], 1'b1};
            end else begin
                r_reg <= r_sh[W-1:0];
                q_reg <= {q_reg[W-2:0], 1'b0};
            end
            cnt <= cnt - CW'(1);
        end else if (fix) begin
            // With D == 0 no step ran, so Q still holds |dividend| and re-signing recovers it.
            if (d_zero) begin
                quotient    <= '1;
                remainder   <= W'(cond_negate(64'(q_reg), sq));
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= W'(cond_negate(64'(q_reg), sd));
                remainder   <= W'(cond_negate(64'(r_reg), sq));
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential signed restoring divider, control FSM over div_datapath
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         RST_n,
    input  logic         GO,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy,
    output logic         done
);

    div_state_t state, state_next;
    logic       load, step, fix, cnt_one, d_zero;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (GO) state_next = LOAD;
            LOAD:    state_next = d_zero ? FIX : ITER;
            ITER:    if (cnt_one) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign load = (state == IDLE) && GO;
    assign step = (state == ITER);
    assign fix  = (state == FIX);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    div_datapath #(.W(W)) u_dp (
        .clk         (clk),
        .rst_n       (RST_n),
        .load        (load),
        .step        (step),
        .fix         (fix),
        .dividend    (dividend),
        .divisor     (divisor),
        .cnt_one     (cnt_one),
        .d_zero      (d_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed scoreboard bench for seq_divider (W=8)
module tb_seq_divider;

    logic       clk;
    logic       RST_n;
    logic       GO;
    logic [7:0] dividend, divisor;
    logic [7:0] quotient, remainder;
    logic       div_by_zero, busy, done;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    seq_divider #(.W(8)) dut (
        .clk         (clk),
        .RST_n       (RST_n),
        .GO          (GO),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa, sbv;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = 8'(sa / sbv); e.r = 8'(sa % sbv); e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_result();
        exp_t e;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("quotient", 32'(quotient), 32'(e.q));
            check("remainder", 32'(remainder), 32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_cyc);
        int cyc;
        bit got;
        @(negedge clk);
        dividend = a; divisor = b; GO = 1'b1;
        sb.push_back(model(a, b));
        cyc = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            GO = 1'b0;
            if (done) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_cycle", 32'(cyc), 32'(exp_cyc));
        check("busy_in_done", 32'(busy), 32'd1);
        if (got) compare_result();
        else void'(sb.pop_front());
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int         last_done, n_done, cyc;
        logic [7:0] a, b;

        RST_n = 1'b0; GO = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        RST_n = 1'b1;

        run_op(8'd100, 8'd7, 11);
        run_op(8'h9C, 8'd7, 11);
        run_op(8'd100, 8'hF9, 11);
        run_op(8'd7, 8'd0, 3);
        run_op(8'h80, 8'hFF, 11);
        run_op(8'd5, 8'd9, 11);
        run_op(8'h80, 8'd0, 3);
        run_op(8'h81, 8'h80, 11);

        // GO held for 30 cycles: accepts at edges 0/12/24, dones in cycles 11/23/35.
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom_range(1, 255));
        dividend = a; divisor = b; GO = 1'b1;
        sb.push_back(model(a, b));
        last_done = 0; n_done = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 30) GO = 1'b0;
            if (done) begin
                n_done++;
                check("b2b_period", 32'(c - last_done), (n_done == 1) ? 32'd11 : 32'd12);
                last_done = c;
                compare_result();
                if (c + 1 < 30) begin
                    a = 8'($urandom); b = 8'($urandom_range(1, 255));
                    dividend = a; divisor = b;
                    sb.push_back(model(a, b));
                end
            end else if (c != last_done + 1) begin
                dividend = 8'($urandom); divisor = 8'($urandom);
            end
        end
        check("b2b_done_count", 32'(n_done), 32'd3);
        check("b2b_sb_drained", 32'(sb.size()), 32'd0);

        // Reset in the ITER cycle holding count = 4 (cycle 6).
        run_op(8'd100, 8'd7, 11);
        @(negedge clk);
        dividend = 8'd50; divisor = 8'd3; GO = 1'b1;
        cyc = 0;
        while (cyc < 6) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            GO = 1'b0;
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        RST_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        RST_n = 1'b1;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("no_done_after_rst", 32'(n_done), 32'd0);
        run_op(8'hF9, 8'd2, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential signed restoring divider, the inverse companion to the team's Booth multiplier. It accepts a W-bit two's-complement dividend and divisor on a GO pulse and iterates one quotient bit per clock. It returns quotient and remainder with truncation toward zero and asserts done for one cycle. It sits beside the multiplier in the arithmetic unit and uses the same GO/done handshake.

## Interface
- W, 8, operand and result width in bits (W ≥ 2)
- clk  in  1  rising-edge clock
- RST_n  in  1  reset, asynchronous and active-low
- GO  in  1  start request; sampled only in IDLE
- dividend  in  W  two's-complement dividend; sampled on the GO-accepting edge
- divisor  in  W  two's-complement divisor; sampled on the GO-accepting edge
- quotient  out  W  registered result; held until the next operation's FIX
- remainder  out  W  registered result; takes the sign of the dividend
- div_by_zero  out  1  registered flag for the current result; same hold rule as quotient
- busy  out  1  high in every state except IDLE
- done  out  1  high only in the DONE state (Moore output)

## Operation
- States:
  - IDLE → LOAD when GO=1; otherwise stays in IDLE.
  - LOAD → ITER, or → FIX if the divisor is zero.
  - ITER → ITER while count ≠ 1; ITER → FIX when count = 1.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- Capture (IDLE, GO-accepting edge):
  - Store sq = dividend sign bit and sd = sign of the quotient (dividend sign XOR divisor sign).
  - Store |dividend| → Q (W bits, unsigned) and |divisor| → D (W bits, unsigned).
  - Store R ← 0 (W+1 bits) and count ← W.
  - |−2^(W−1)| = 2^(W−1) fits unsigned W.
- LOAD: evaluates D == 0.
- ITER, one step per cycle:
  - Shift {R,Q} left by 1.
  - Compute t = R − {1'b0,D} in W+1 bits.
  - If t ≥ 0: R ← t and Q[0] ← 1. Otherwise R is unchanged and Q[0] ← 0.
  - count ← count − 1.
- FIX:
  - quotient ← sd ? −Q : Q (mod 2^W).
  - remainder ← sq ? −R[W−1:0] : R[W−1:0].
  - div_by_zero ← 0.
- Divide by zero (reached via LOAD → FIX):
  - quotient ← all ones.
  - remainder ← original dividend.
  - div_by_zero ← 1.
- Overflow −2^(W−1) / −1: quotient = −2^(W−1) (wraps), remainder = 0, no flag.
- GO while busy is ignored, including during DONE. There is no queuing.
- Operand inputs are don't-care outside the GO-accepting edge.

## Timing
- Edge numbering: GO is sampled high in IDLE at edge 0.
- Normal division:
  - LOAD occupies cycle 1.
  - ITER occupies edges 2 through W+1.
  - FIX is entered after edge W+1.
  - DONE is entered after edge W+2; done=1 during cycle W+3.
  - Back in IDLE after edge W+3.
  - W=8: done during cycle 11.
- Divide by zero: done occurs during cycle 3.
- Results are valid from the DONE cycle onward and remain stable until the FIX of the next operation.
- GO held high continuously produces back-to-back operations with exactly one IDLE cycle between DONE and the next LOAD.
- Reset:
  - RST_n low forces IDLE immediately, in any state.
  - All outputs go to 0: quotient, remainder, div_by_zero, busy, done.
  - Internal registers go to 0.
  - An operation interrupted mid-ITER is discarded and never signals done.
  - After RST_n deasserts, the first edge sees IDLE.

## Structure
- Shared arithmetic package:
  - State encoding typedef: IDLE, LOAD, ITER, FIX, DONE (3 bits).
  - Default width constant.
  - Helper function for the W-bit two's-complement absolute value and negation. The multiplier can reuse it.
- Sub-module div_datapath holds R/Q/D, the subtractor, the counter and the sign-fix logic. It is driven by a control FSM in seq_divider, mirroring the multiplier's CU/datapath split.
- The datapath reports count == 1 and D == 0 to the FSM.

## Test plan
All scenarios use W=8.
- 100 / 7 → quotient 0x0E, remainder 0x02, div_by_zero 0, done high during cycle 11 only.
- −100 / 7 → quotient 0xF2 (−14), remainder 0xFE (−2). Repeat with 100 / −7 → quotient 0xF2, remainder 0x02.
- 7 / 0 → quotient 0xFF, remainder 0x07, div_by_zero 1, done during cycle 3.
- −128 / −1 → quotient 0x80, remainder 0x00, div_by_zero 0. Then 5 / 9 → quotient 0, remainder 5.
- GO held high for 30 cycles with new operands each accept → done pulses every 12 cycles. GO pulses during busy have no effect on results.
- RST_n pulled low in the ITER cycle where count = 4 → busy=0, all outputs 0 immediately, no done afterwards. A new GO then completes correctly.
